// File: rtl/timer_run_controller.sv
`default_nettype none
// ============================================================================
// timer_run_controller
// Initiator side of the tick/run/reached timer interface: clears the counter,
// arms it with a prescaled tick, and reports done/timeout with a watchdog.
// Optional macro TIMER_RUN_CONTROLLER_REACHED_SYNC_EN: two-flop reached sync.
// Revision: 1.0
// ============================================================================

module timer_run_controller #(
  parameter int unsigned TICK_DIV       = 4,
  parameter int unsigned CLEAR_CYCLES   = 2,
  parameter logic [15:0] WATCHDOG_TICKS = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        reached,
  output logic        tick,
  output logic        run,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] tick_count
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_ARM     = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_TIMEOUT = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] clear_cnt_q, clear_cnt_d;
  logic          tick_q, tick_d;
  logic          run_q, run_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic [15:0]   tick_count_q, tick_count_d;
  logic          reached_s;

`ifdef TIMER_RUN_CONTROLLER_REACHED_SYNC_EN
  logic reached_meta_q, reached_meta_d;
  logic reached_sync_q, reached_sync_d;

  always_comb begin
    reached_meta_d = reached;
    reached_sync_d = reached_meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reached_meta_q <= 1'b0;
      reached_sync_q <= 1'b0;
    end else begin
      reached_meta_q <= reached_meta_d;
      reached_sync_q <= reached_sync_d;
    end
  end

  assign reached_s = reached_sync_q;
`else
  logic reached_reg_q, reached_reg_d;

  always_comb begin
    reached_reg_d = reached;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reached_reg_q <= 1'b0;
    end else begin
      reached_reg_q <= reached_reg_d;
    end
  end

  assign reached_s = reached_reg_q;
`endif

  // Outputs are decoded from the next state so each registered output lines
  // up with the state it describes.
  always_comb begin
    state_d      = state_q;
    clear_cnt_d  = '0;
    presc_d      = '0;
    tick_count_d = tick_count_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_CLEAR;
          tick_count_d = '0;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (clear_cnt_q == CLEAR_LAST) begin
          state_d = S_ARM;
        end else begin
          clear_cnt_d = clear_cnt_q + 1'b1;
        end
      end
      S_ARM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (reached_s) begin
          state_d = S_DONE;
        end else if (tick_count_q >= WATCHDOG_TICKS) begin
          state_d = S_TIMEOUT;
        end else begin
          presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        end
      end
      S_DONE, S_TIMEOUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Leaving ARM (reached, watchdog, abort) naturally suppresses a due tick.
    tick_d = (state_d == S_ARM) && (presc_d == PRESC_LAST);
    if (tick_d && (tick_count_q != 16'hFFFF)) begin
      tick_count_d = tick_count_q + 16'd1;
    end

    run_d     = (state_d == S_ARM);
    busy_d    = (state_d == S_CLEAR) || (state_d == S_ARM);
    done_d    = (state_d == S_DONE);
    timeout_d = (state_d == S_TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      clear_cnt_q  <= '0;
      tick_q       <= 1'b0;
      run_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      clear_cnt_q  <= clear_cnt_d;
      tick_q       <= tick_d;
      run_q        <= run_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      tick_count_q <= tick_count_d;
    end
  end

  assign tick       = tick_q;
  assign run        = run_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign tick_count = tick_count_q;

endmodule

`default_nettype wire

// File: doc/timer_run_controller.md
Name: timer_run_controller

Overview:
- Initiator side of the tick/run/reached timer interface.
- Drives `run` and a prescaled `tick` strobe into a downstream threshold counter, then watches that counter's `reached` flag.
- Offers user logic a start/abort command handshake with done and timeout pulses.
- Guarantees the counter is cleared before each measurement, by holding `run` low, and bounds every wait with a watchdog.

Parameters:
- TICK_DIV, 4: clk cycles per tick period; must be at least 2.
- CLEAR_CYCLES, 2: clk cycles `run` is held low before arming; must be at least 1.
- WATCHDOG_TICKS, 16'hFFFF: ticks issued without `reached` before timeout is declared.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a timed interval; sampled only in IDLE
- abort  in  1  cancel the interval in progress
- reached  in  1  threshold flag from the downstream counter; asynchronous to clk
- tick  out  1  one-clk-wide strobe to the counter
- run  out  1  counter enable; low clears the counter
- busy  out  1  interval in progress
- done  out  1  one-cycle pulse: `reached` observed
- timeout  out  1  one-cycle pulse: watchdog expired
- tick_count  out  16  ticks issued in the current or last interval, saturating

Behaviour:
- Interface: one clock; reset is synchronous and active-high (`rst`, sampled on `clk` rising edge).
- Reset values: state IDLE; prescaler 0; tick, run, busy, done, timeout = 0; tick_count = 0.
- Reset mid-operation: all outputs take reset values on the next edge. `run` low clears the downstream counter.
- All outputs are registered.
- reached_s is the sampled `reached`:
  - one register stage (1 clk latency) by default;
  - see Optional Feature for the synchronised variant.
- States:
  - IDLE:
    - run=0, busy=0.
    - start=1 -> CLEAR. tick_count cleared to 0 on the same edge.
  - CLEAR:
    - run=0, busy=1.
    - Stays exactly CLEAR_CYCLES cycles, then -> ARM.
    - Prescaler forced to 0.
  - ARM:
    - run=1, busy=1.
    - Prescaler counts 0..TICK_DIV-1, then wraps.
    - When prescaler==TICK_DIV-1: tick=1 for that one cycle, and tick_count increments on the same edge (saturates at 16'hFFFF, no wrap).
    - The first tick occurs in the TICK_DIV-th ARM cycle. tick is low in all other cycles and all other states.
    - reached_s=1 -> DONE.
    - Else tick_count >= WATCHDOG_TICKS and reached_s=0 -> TIMEOUT.
  - DONE:
    - done=1, run=0, busy=0 for one cycle, then -> IDLE.
  - TIMEOUT:
    - timeout=1, run=0, busy=0 for one cycle, then -> IDLE.
- Priorities:
  - rst > abort > reached_s > watchdog > prescaler tick.
  - A tick due in the same cycle reached_s is seen is suppressed.
- abort:
  - In CLEAR or ARM -> IDLE next cycle: run=0, tick=0, no done/timeout pulse.
  - tick_count holds its value.
  - Ignored in IDLE, DONE and TIMEOUT.
- start:
  - Ignored outside IDLE, including in DONE and TIMEOUT; it is not queued.
  - start held high re-triggers from IDLE: back-to-back intervals, with one IDLE cycle between them.
- reached already high on entering ARM (stale counter):
  - CLEAR guarantees it drops before arming.
  - If reached_s=1 in the first ARM cycle, DONE is taken with tick_count=0.
- tick_count holds its final value until the next start.

Optional Feature:
- Macro: TIMER_RUN_CONTROLLER_REACHED_SYNC_EN.
- Defined: `reached` passes through a two-flop synchroniser before use; reached-to-DONE latency is 2 clk.
- Undefined: single register stage; latency is 1 clk.
- All other behaviour is identical in both builds.

Test Plan:
- Common setup:
  - TICK_DIV=4, CLEAR_CYCLES=2, WATCHDOG_TICKS=8.
  - Bench counter model asserts `reached` after its 6th tick, while run=1.
- Reset/idle:
  - Stimulus: rst high 3 cycles, then low 10 cycles, start=0.
  - Required: all outputs 0 throughout.
- Nominal interval:
  - Stimulus: start pulsed 1 cycle.
  - Required: busy=1 next cycle; run=0 for 2 cycles, then 1; ticks every 4 clk.
  - Required: exactly 6 ticks, then done=1 for 1 cycle, run=0, busy=0, tick_count=6.
  - Run in both macro builds; the only permitted difference is the 1-cycle shift in done.
- Watchdog:
  - Stimulus: counter model never asserts `reached`.
  - Required: after the 8th tick, timeout=1 for 1 cycle, done stays 0, tick_count=8, no 9th tick.
- Abort:
  - Stimulus: start, then abort after the 3rd tick.
  - Required: run=0 and busy=0 next cycle; no done or timeout pulse; tick_count=3.
- Ignored start and reset mid-run:
  - Stimulus: start pulsed again while in ARM.
  - Required: no restart; tick_count=6 at done.
  - Stimulus: rst asserted in ARM.
  - Required: all outputs 0 next cycle.
- Stale reached:
  - Stimulus: `reached` held high by the model.
  - Required: completes with tick_count=0 and a done pulse.
